// File: rtl/irq_f2p_sched.sv
`default_nettype none
// ============================================================================
//  Module   : irq_f2p_sched
//  Purpose  : Rate-limited round-robin scheduler that turns per-source request
//             pulses into paced PL->PS interrupts on IRQ_F2P[0] (level line)
//             and IRQ_F2P[1] (edge line). Each grant holds its line high for
//             HOLD_CYC cycles, then forces GAP_CYC all-low cycles before the
//             next grant may be issued.
//  Options  : define IRQ_F2P_SCHED_CNT_EN to add the per-source saturating
//             16-bit grant counters on output grant_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_f2p_sched #(
  parameter int               N_SRC    = 4,
  parameter logic [N_SRC-1:0] SRC_EDGE = 4'b1100,
  parameter int               HOLD_CYC = 256,
  parameter int               GAP_CYC  = 25600
) (
  input  logic                 clk100_fclk0,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     req,
  input  logic                 ovf_clr,
  output logic                 irq_f2p0,
  output logic                 irq_f2p1,
  output logic [N_SRC-1:0]     pending,
  output logic [N_SRC-1:0]     overflow,
  output logic                 busy,
`ifdef IRQ_F2P_SCHED_CNT_EN
  output logic [N_SRC*16-1:0]  grant_cnt,
`endif
  output logic [2:0]           grant_id
);

  // One shared down-counter serves both the hold and the gap phase, so it is
  // sized for the longer of the two.
  localparam int                 c_cnt_max  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int                 c_cnt_w    = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [2:0]         c_last_src  = 3'(N_SRC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Registered state
  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_irq0;
  logic                 r_irq1;
  logic                 r_busy;
  logic [N_SRC-1:0]     r_pending;
  logic [N_SRC-1:0]     r_overflow;
  logic [2:0]           r_grant_id;

  // Combinational next-state / arbitration results
  state_t               w_state_d;
  logic [c_cnt_w-1:0]   w_cnt_d;
  logic                 w_irq0_d;
  logic                 w_irq1_d;
  logic                 w_fire;
  logic [2:0]           w_start;
  logic                 w_found;
  logic [N_SRC-1:0]     w_grant_oh;
  logic [2:0]           w_grant_idx;
  logic                 w_edge_sel;
  logic [N_SRC-1:0]     w_grant_mask;
  logic [N_SRC-1:0]     w_new_ovf;
  logic [N_SRC-1:0]     w_pending_d;
  logic [N_SRC-1:0]     w_overflow_d;

  // Round-robin pick: scan from the slot after the last grant up to the top,
  // then wrap and scan from source 0 up to (but excluding) the start slot.
  always_comb begin
    w_start     = (r_grant_id >= c_last_src) ? 3'd0 : r_grant_id + 3'd1;
    w_found     = 1'b0;
    w_grant_oh  = '0;
    w_grant_idx = 3'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_found && r_pending[i] && (3'(i) >= w_start)) begin
        w_found       = 1'b1;
        w_grant_oh[i] = 1'b1;
        w_grant_idx   = 3'(i);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_found && r_pending[i] && (3'(i) < w_start)) begin
        w_found       = 1'b1;
        w_grant_oh[i] = 1'b1;
        w_grant_idx   = 3'(i);
      end
    end
  end

  // Line selection for the picked source: 1 -> edge line, 0 -> level line.
  assign w_edge_sel = |(w_grant_oh & SRC_EDGE);

  // FSM next-state, counter and IRQ-line next values.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_irq0_d  = r_irq0;
    w_irq1_d  = r_irq1;
    w_fire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_d = ASSERT;
          w_cnt_d   = c_hold_load;
          w_fire    = 1'b1;
          w_irq0_d  = ~w_edge_sel;
          w_irq1_d  = w_edge_sel;
        end
      end
      ASSERT: begin
        if (r_cnt == '0) begin
          w_state_d = GAP;
          w_cnt_d   = c_gap_load;
          w_irq0_d  = 1'b0;
          w_irq1_d  = 1'b0;
        end else begin
          w_cnt_d = r_cnt - c_cnt_one;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_d = IDLE;
        end else begin
          w_cnt_d = r_cnt - c_cnt_one;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_cnt_d   = '0;
        w_irq0_d  = 1'b0;
        w_irq1_d  = 1'b0;
      end
    endcase
  end

  // Request bookkeeping: a grant consumes the pending bit, but a request on
  // the very same edge re-arms it without counting as an overflow.
  always_comb begin
    w_grant_mask = w_fire ? w_grant_oh : '0;
    w_new_ovf    = req & r_pending & ~w_grant_mask;
    w_pending_d  = (r_pending & ~w_grant_mask) | req;
    w_overflow_d = (ovf_clr ? '0 : r_overflow) | w_new_ovf;
  end

  // FSM state register.
  always_ff @(posedge clk100_fclk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Counter, registered outputs and request/overflow flags.
  always_ff @(posedge clk100_fclk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_irq0     <= 1'b0;
      r_irq1     <= 1'b0;
      r_busy     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= '0;
      r_grant_id <= c_last_src;
    end else begin
      r_cnt      <= w_cnt_d;
      r_irq0     <= w_irq0_d;
      r_irq1     <= w_irq1_d;
      r_busy     <= (w_state_d != IDLE);
      r_pending  <= w_pending_d;
      r_overflow <= w_overflow_d;
      if (w_fire) begin
        r_grant_id <= w_grant_idx;
      end
    end
  end

`ifdef IRQ_F2P_SCHED_CNT_EN
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_grant_cnt
      logic [15:0] r_gcnt;

      // Per-source grant tally, sticks at all-ones instead of wrapping.
      always_ff @(posedge clk100_fclk0 or negedge rst_n) begin
        if (!rst_n) begin
          r_gcnt <= 16'd0;
        end else if (w_grant_mask[gi] && (r_gcnt != 16'hFFFF)) begin
          r_gcnt <= r_gcnt + 16'd1;
        end
      end

      assign grant_cnt[gi*16 +: 16] = r_gcnt;
    end
  endgenerate
`endif

  assign irq_f2p0 = r_irq0;
  assign irq_f2p1 = r_irq1;
  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule
`default_nettype wire
